nn_sequencer: RTL and testbench

NN_SEQUENCER -- requirements
Module: nn_sequencer

---
 rtl/nn_sequencer.sv | 66 ++++++
 tb/tb_nn_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/nn_sequencer.sv
// nn_sequencer: control FSM sequencing a two-layer neural inference over S hidden steps
module nn_sequencer #(
  parameter int S  = 8,
  parameter int AW = 3,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          x_load,
  output logic [AW-1:0] addr_r,
  output logic [AW-1:0] addr_c,
  output logic          acc_en,
  output logic          acc_clr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic [CW-1:0] inf_count
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [AW-1:0] k, k_nx;
  logic last;
  assign last      = k == AW'(S - 1);
  assign in_ready  = state == IDLE;
  assign x_load    = in_valid & in_ready;
  assign busy      = state != IDLE;
  assign out_valid = state == DONE;
  assign addr_r    = state == RUN ? k : '0;
  // next state and step counter; k only counts inside RUN and parks at 0 otherwise
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = in_valid ? RUN : IDLE;
      RUN:     state_nx = last ? DRAIN : RUN;
      DRAIN:   state_nx = DONE;
      default: state_nx = out_ready ? IDLE : DONE;
    endcase
    k_nx = (state == RUN && !last) ? k + 1'b1 : '0;
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      k     <= '0;
    end else begin
      state <= state_nx;
      k     <= k_nx;
    end
  end
  // layer-2 controls trail layer-1 by one stage to line up with the registered H
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_c    <= '0;
      acc_en    <= 1'b0;
      acc_clr   <= 1'b0;
      inf_count <= '0;
    end else begin
      addr_c  <= addr_r;
      acc_en  <= state == RUN;
      acc_clr <= state == RUN && k == '0;
      if (state == DONE && out_ready) inf_count <= inf_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_nn_sequencer.sv
// tb_nn_sequencer: directed self-checking bench for nn_sequencer (S=8 build and S=2/CW=2 build)
module tb_nn_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, x_load, acc_en, acc_clr, out_valid, busy;
  logic [2:0] addr_r, addr_c;
  logic [15:0] inf_count;
  logic iv_b = 1'b0, or_b = 1'b0;
  logic ir_b, xl_b, ae_b, ac_b, ov_b, busy_b;
  logic [0:0] ar_b, acb_b;
  logic [1:0] ic_b;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  nn_sequencer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .x_load(x_load),
    .addr_r(addr_r), .addr_c(addr_c), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .inf_count(inf_count)
  );

  nn_sequencer #(.S(2), .AW(1), .CW(2)) dut_b (
    .clk(clk), .reset(reset), .in_valid(iv_b), .in_ready(ir_b), .x_load(xl_b),
    .addr_r(ar_b), .addr_c(acb_b), .acc_en(ae_b), .acc_clr(ac_b),
    .out_valid(ov_b), .out_ready(or_b), .busy(busy_b), .inf_count(ic_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input string tag, input int cnt);
    chk({tag, ".in_ready"}, 32'(in_ready), 1);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".out_valid"}, 32'(out_valid), 0);
    chk({tag, ".addr_r"}, 32'(addr_r), 0);
    chk({tag, ".addr_c"}, 32'(addr_c), 0);
    chk({tag, ".acc_en"}, 32'(acc_en), 0);
    chk({tag, ".acc_clr"}, 32'(acc_clr), 0);
    chk({tag, ".inf_count"}, 32'(inf_count), 32'(cnt));
  endtask

  task automatic infer_a(input int bp, input int cnt0);
    chk("pre.in_ready", 32'(in_ready), 1);
    in_valid = 1'b1;
    #1 chk("accept.x_load", 32'(x_load), 1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("run%0d.addr_r", i), 32'(addr_r), 32'(i));
      chk($sformatf("run%0d.addr_c", i), 32'(addr_c), i > 0 ? 32'(i - 1) : 0);
      chk($sformatf("run%0d.acc_en", i), 32'(acc_en), i > 0 ? 1 : 0);
      chk($sformatf("run%0d.acc_clr", i), 32'(acc_clr), i == 1 ? 1 : 0);
      chk($sformatf("run%0d.busy", i), 32'(busy), 1);
      chk($sformatf("run%0d.in_ready", i), 32'(in_ready), 0);
      chk($sformatf("run%0d.out_valid", i), 32'(out_valid), 0);
      @(negedge clk);
    end
    chk("drain.addr_r", 32'(addr_r), 0);
    chk("drain.addr_c", 32'(addr_c), 7);
    chk("drain.acc_en", 32'(acc_en), 1);
    chk("drain.acc_clr", 32'(acc_clr), 0);
    chk("drain.out_valid", 32'(out_valid), 0);
    @(negedge clk);
    for (int i = 0; i < bp; i++) begin
      chk("bp.out_valid", 32'(out_valid), 1);
      chk("bp.acc_en", 32'(acc_en), 0);
      chk("bp.busy", 32'(busy), 1);
      chk("bp.inf_count", 32'(inf_count), 32'(cnt0));
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("done.out_valid", 32'(out_valid), 1);
    chk("done.acc_en", 32'(acc_en), 0);
    chk("done.addr_c", 32'(addr_c), 0);
    chk("done.inf_count", 32'(inf_count), 32'(cnt0));
    @(negedge clk);
    out_ready = 1'b0;
    idle_chk("post", cnt0 + 1);
  endtask

  task automatic infer_b(input int exp_cnt);
    int n, ae;
    n = 0;
    ae = 0;
    iv_b = 1'b1;
    #1 chk("b.x_load", 32'(xl_b), 1);
    @(negedge clk);
    iv_b = 1'b0;
    n = 1;
    while (!ov_b && n < 20) begin
      ae += int'(ae_b);
      @(negedge clk);
      n++;
    end
    chk("b.latency", 32'(n - 1), 3);
    chk("b.acc_en_cycles", 32'(ae), 2);
    or_b = 1'b1;
    @(negedge clk);
    or_b = 1'b0;
    chk("b.out_valid_after", 32'(ov_b), 0);
    chk("b.inf_count", 32'(ic_b), 32'(exp_cnt));
  endtask

  initial begin
    int ov;
    repeat (2) @(negedge clk);
    idle_chk("reset", 0);
    chk("reset.b.in_ready", 32'(ir_b), 1);
    reset = 1'b0;
    @(negedge clk);
    idle_chk("idle", 0);
    // single inference with 5 cycles of backpressure, then one with immediate out_ready
    infer_a(5, 0);
    infer_a(0, 1);
    // in_valid held high through two inferences
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle_chk("reset2", 0);
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1 chk("hold.x_load0", 32'(x_load), 1);
    for (int r = 1; r <= 2; r++) begin
      for (int j = 0; j < 9; j++) begin
        @(negedge clk);
        chk("hold.in_ready", 32'(in_ready), 0);
        chk("hold.x_load", 32'(x_load), 0);
      end
      @(negedge clk);
      chk("hold.out_valid", 32'(out_valid), 1);
      chk("hold.x_load_done", 32'(x_load), 0);
      @(negedge clk);
      chk("hold.x_load_idle", 32'(x_load), 1);
      chk("hold.inf_count", 32'(inf_count), 32'(r));
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    // reset in the middle of RUN
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid.addr_r", 32'(addr_r), 4);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle_chk("mid.reset", 0);
    ov = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      ov += int'(out_valid);
    end
    chk("mid.no_out_valid", 32'(ov), 0);
    infer_a(0, 0);
    // S=2, CW=2 build: five inferences wrap the counter to 1
    for (int i = 1; i <= 5; i++) infer_b(i % 4);
    chk("b.wrap", 32'(ic_b), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
